// File: rtl/qe_pkg.sv
// Shared types and constants for the quadratic-equation / product-sum result path.
// Used by qe_result_buffer, its interface and the qe_sync_fifo storage.
package qe_pkg;

  // Width of a MAC result.
  localparam int QE_DATA_W = 16;

  // Mode tag carried alongside every result.
  localparam logic MODE_QE = 1'b0;  // quadratic equation
  localparam logic MODE_PS = 1'b1;  // product-sum

  // One FIFO entry: the result and the mode it was produced in.
  typedef struct packed {
    logic                 mode;
    logic [QE_DATA_W-1:0] data;
  } qe_result_t;

endpackage

// File: rtl/qe_result_buffer_if.sv
// Handshake bundle for qe_result_buffer: the MAC-side result strobe and the
// consumer-side valid/ready port. The buffer uses the slave modport; whatever
// drives results in and drains them out uses the master modport.
interface qe_result_buffer_if
  import qe_pkg::*;
#(
  parameter int DATA_W = QE_DATA_W
);

  logic              in_valid;
  logic [DATA_W-1:0] in_result;
  logic              in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_mode;

  modport master (
    output in_valid, in_result, in_mode, out_ready,
    input  out_valid, out_data, out_mode
  );

  modport slave (
    input  in_valid, in_result, in_mode, out_ready,
    output out_valid, out_data, out_mode
  );

endinterface

// File: rtl/qe_sync_fifo.sv
// Show-ahead synchronous FIFO of qe_result_t entries. The occupancy counter
// is kept separately from the pointers, so full and empty never rely on
// pointer equality. The caller decides when push/pop are legal.
module qe_sync_fifo
  import qe_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  qe_result_t       wdata_i,
  output qe_result_t       rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  qe_result_t             mem_q [DEPTH];
  logic       [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic       [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic       [CNT_W-1:0] cnt_q,    cnt_d;

  // Write the incoming entry into the slot under the write pointer.
  // NOTE: the storage array has no reset; only pointers and the counter do,
  // and empty slots are never presented because rdata_o is masked below.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Next-state for pointers and occupancy; flush clears everything and
  // overrides any push or pop in the same cycle.
  // NOTE: every signal gets its default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Register pointers and occupancy; reset wins over everything.
  // NOTE: state registers use non-blocking assignments so all flops update
  // together on the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  // Head entry is shown directly; an empty FIFO presents zeros.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/qe_result_buffer.sv
// Output stage behind the quadratic-equation / product-sum MAC. Captures each
// result on the MAC valid strobe, tags it with its mode, buffers it in a
// show-ahead FIFO and hands it to a consumer over valid/ready. Results that
// arrive while the buffer is full and not draining are dropped and flagged.
// Optional build macro QE_RB_MAX_EN adds a max_result output tracking the
// largest unsigned result accepted since reset or flush.
module qe_result_buffer
  import qe_pkg::*;
#(
  parameter  int DEPTH  = 8,
  // Must equal QE_DATA_W: the FIFO entry type is fixed to that width.
  parameter  int DATA_W = QE_DATA_W,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  qe_result_buffer_if.slave bus,
  input  logic              flush,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              overflow,
  output logic [15:0]       accepted_cnt
`ifdef QE_RB_MAX_EN
  ,
  output logic [DATA_W-1:0] max_result
`endif
);

  logic       push;
  logic       pop;
  logic       empty;
  qe_result_t wdata;
  qe_result_t rdata;

  logic        overflow_q, overflow_d;
  logic [15:0] acc_cnt_q,  acc_cnt_d;

  // A pop needs a head entry; a push needs room or a simultaneous pop.
  // Flush suppresses both.
  assign pop   = !empty && bus.out_ready && !flush;
  assign push  = bus.in_valid && (!full || pop) && !flush;

  assign wdata = '{mode: bus.in_mode, data: bus.in_result};

  qe_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.out_valid = !empty;
  assign bus.out_data  = rdata.data;
  assign bus.out_mode  = rdata.mode;

  // Sticky drop flag and accepted-result counter; a result discarded by
  // flush is not a drop.
  always_comb begin
    overflow_d = overflow_q;
    acc_cnt_d  = acc_cnt_q;
    if (flush) begin
      overflow_d = 1'b0;
      acc_cnt_d  = '0;
    end else begin
      if (bus.in_valid && !push) overflow_d = 1'b1;
      if (push)                  acc_cnt_d  = acc_cnt_q + 16'd1;
    end
  end

  // Register the drop flag and the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      acc_cnt_q  <= '0;
    end else begin
      overflow_q <= overflow_d;
      acc_cnt_q  <= acc_cnt_d;
    end
  end

  assign overflow     = overflow_q;
  assign accepted_cnt = acc_cnt_q;

`ifdef QE_RB_MAX_EN
  logic [DATA_W-1:0] max_q, max_d;

  // Track the largest accepted result; dropped results never count.
  always_comb begin
    max_d = max_q;
    if (flush)                                max_d = '0;
    else if (push && (bus.in_result > max_q)) max_d = bus.in_result;
  end

  // Register the running maximum.
  always_ff @(posedge clk) begin
    if (reset) max_q <= '0;
    else       max_q <= max_d;
  end

  assign max_result = max_q;
`endif

endmodule

// File: doc/qe_result_buffer.md
Name: qe_result_buffer

Overview:
- Output stage directly downstream of the quadratic-equation / product-sum MAC top level.
- Captures each 16-bit result on the MAC's one-cycle valid_out strobe and tags it with the active mode.
- Stores results in a small synchronous FIFO and presents them to a consumer over a valid/ready handshake.
- The MAC has no backpressure, so this block absorbs bursts and flags any loss.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- DATA_W, 16, result width; matches the MAC result.

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  result strobe from the MAC valid_out
- in_result  input  DATA_W  MAC result
- in_mode  input  1  MAC mode; 0 = quadratic, 1 = product-sum
- flush  input  1  synchronous clear of contents and flags
- out_valid  output  1  head entry available
- out_ready  input  1  consumer accepts head entry
- out_data  output  DATA_W  head result
- out_mode  output  1  head mode tag
- count  output  $clog2(DEPTH)+1  current occupancy
- full  output  1  count == DEPTH
- overflow  output  1  sticky: a result was dropped
- accepted_cnt  output  16  results written since reset or flush; wraps

Behaviour:
- Reset, sampled on the clk edge while high:
  - occupancy 0, pointers 0.
  - out_valid=0, out_data=0, out_mode=0, count=0, full=0, overflow=0, accepted_cnt=0.
  - Reset has priority over all other inputs.
- Push: in_valid && (!full || pop).
  - Writes {in_mode, in_result} at the write pointer.
  - Increments accepted_cnt.
- Pop: out_valid && out_ready. Advances the read pointer.
- Show-ahead FIFO: out_data and out_mode always reflect the head entry; out_valid = (count != 0).
- Latency: a push into an empty buffer at edge N gives out_valid=1 with that data after edge N. There is no same-cycle bypass from in_result to out_data.
- Simultaneous push and pop:
  - Count unchanged.
  - Allowed when full: the freed slot is reused.
  - When empty, only the push occurs, since out_valid=0.
- Full with in_valid and no pop:
  - The result is dropped; contents are unchanged.
  - overflow is set; accepted_cnt does not increment.
- out_ready while empty: no effect.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked by a separate counter; full and empty are never inferred from pointer equality alone.
- flush, when reset is low:
  - Next cycle: count=0, out_valid=0, overflow=0, accepted_cnt=0.
  - Any push or pop in the same cycle is ignored; an in_valid result that cycle is discarded without setting overflow.
- overflow is cleared only by reset or flush.
- accepted_cnt wraps 0xFFFF -> 0x0000 silently.
- in_mode is sampled with in_result on the same edge; mode changes between results have no other effect.
- No state machine is required beyond the FIFO and counters; behaviour is a pure function of push/pop/flush each cycle.

Optional Feature:
- Macro: QE_RB_MAX_EN.
- When defined:
  - Adds output max_result [DATA_W-1:0], holding the largest unsigned result accepted since reset or flush.
  - Reset and flush set it to 0.
  - Updated on every accepted push where in_result > max_result.
  - Dropped results do not update it.
- When undefined: the port and its register are absent. All other behaviour is identical.

Decomposition:
- Package qe_pkg:
  - DATA_W default constant.
  - Mode constants MODE_QE=1'b0 and MODE_PS=1'b1.
  - Packed struct qe_result_t {mode, data}, used as the FIFO entry type.
- One sub-module, qe_sync_fifo:
  - Storage array, pointers and occupancy counter.
  - Push/pop/flush inputs.
- qe_result_buffer wraps it with the drop/overflow logic, accepted_cnt, and the optional max tracker.

Test Plan:
- Reset, then one in_valid with in_result=0x1234 and in_mode=0 -> next cycle out_valid=1, out_data=0x1234, out_mode=0, count=1, accepted_cnt=1. Assert out_ready -> empty the following cycle.
- 8 pushes (0x0001..0x0008) with out_ready=0 -> full=1, count=8. A 9th push of 0x0009 -> overflow=1, accepted_cnt=8. Draining yields 0x0001..0x0008 in order.
- Full buffer, in_valid=0x00AA with out_ready=1 in the same cycle -> count stays 8, no overflow, 0x00AA is the last entry drained.
- Alternate in_mode 0/1 across pushes 0x0010..0x0013 -> out_mode sequence 0,1,0,1 on drain.
- Three entries present, flush together with in_valid=0x0055 -> next cycle count=0, out_valid=0, overflow=0, accepted_cnt=0. 0x0055 never appears.
- With QE_RB_MAX_EN defined, push 0x0100, 0xFFF0, 0x0200 -> max_result=0xFFF0. After flush, max_result=0.
